// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizes for the dual-requester RAM port controller.
package ram_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;

    typedef enum logic {CLEAR, ARB} arb_state_t;
    typedef enum logic {SEL_A, SEL_B} sel_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic; last_grant resets to B so A wins the first tie.
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    sel_t last_grant_q;
    sel_t last_grant_d;

    always_comb begin
        gnt_a = en & req_a & (~req_b | (last_grant_q == SEL_B));
        gnt_b = en & req_b & ~gnt_a;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_a) begin
            last_grant_d = SEL_A;
        end else if (gnt_b) begin
            last_grant_d = SEL_B;
        end
    end

    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= SEL_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B after clearing it to zero.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              init_done,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

    arb_state_t        state_q, state_d, state_act;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d, clr_act;
    logic              init_done_q, init_done_d;
    logic              rvalid_a_q, rvalid_b_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic              rd_a, rd_b;

    // Reset held low forces the outputs to the first clear cycle before any edge lands.
    assign state_act = reset_n ? state_q : CLEAR;
    assign clr_act   = reset_n ? clr_cnt_q : '0;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_act == ARB),
        .req_a   (req_a),
        .req_b   (req_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + CLR_ONE;
            if (clr_cnt_q == CLR_LAST) begin
                state_d     = ARB;
                init_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        ram_wr_en   = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        case (state_act)
            CLEAR: begin
                ram_wr_en = 1'b1;
                ram_addr  = clr_act[ADDR_W-1:0];
            end
            ARB: begin
                if (gnt_a) begin
                    ram_wr_en   = we_a;
                    ram_addr    = addr_a;
                    ram_wr_data = wdata_a;
                end else if (gnt_b) begin
                    ram_wr_en   = we_b;
                    ram_addr    = addr_b;
                    ram_wr_data = wdata_b;
                end
            end
            default: ;
        endcase
    end

    assign rd_a = gnt_a & ~we_a;
    assign rd_b = gnt_b & ~we_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            rvalid_a_q <= rd_a;
            rvalid_b_q <= rd_b;
            if (rd_a) rdata_a_q <= ram_rd_data;
            if (rd_b) rdata_b_q <= ram_rd_data;
        end
    end

    assign init_done = init_done_q;
    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: grant checks inline, read data via a scoreboard.
module tb_ram_port_arbiter;
    import ram_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
    logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data, ram_rd_data;

    logic [DATA_W-1:0] mem [DEPTH];

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The RAM the controller drives: synchronous write, combinational read.
    always @(posedge clk) if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    assign ram_rd_data = mem[ram_addr];

    ram_port_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_a       (req_a),
        .we_a        (we_a),
        .addr_a      (addr_a),
        .wdata_a     (wdata_a),
        .gnt_a       (gnt_a),
        .rvalid_a    (rvalid_a),
        .rdata_a     (rdata_a),
        .req_b       (req_b),
        .we_b        (we_b),
        .addr_b      (addr_b),
        .wdata_b     (wdata_b),
        .gnt_b       (gnt_b),
        .rvalid_b    (rvalid_b),
        .rdata_b     (rdata_b),
        .init_done   (init_done),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: each rvalid pops one expected read and checks its data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rvalid_a === 1'b1) begin
                if (qa.size() == 0) check("rvalid_a_unexpected", 32'(rvalid_a), 0);
                else begin
                    e = qa.pop_front();
                    check("rvalid_a_latency", cyc, e.due);
                    check("rdata_a", 32'(rdata_a), 32'(e.data));
                end
            end else if (qa.size() > 0 && qa[0].due <= cyc) begin
                e = qa.pop_front();
                check("rvalid_a_missing", 32'(rvalid_a), 1);
            end
            if (rvalid_b === 1'b1) begin
                if (qb.size() == 0) check("rvalid_b_unexpected", 32'(rvalid_b), 0);
                else begin
                    e = qb.pop_front();
                    check("rvalid_b_latency", cyc, e.due);
                    check("rdata_b", 32'(rdata_b), 32'(e.data));
                end
            end else if (qb.size() > 0 && qb[0].due <= cyc) begin
                e = qb.pop_front();
                check("rvalid_b_missing", 32'(rvalid_b), 1);
            end
        end
    end

    // One cycle of traffic: drive, check grants mid-cycle, queue expected reads, advance.
    task automatic step(input logic ra, input logic wa, input int aa, input int da,
                        input logic rb, input logic wb, input int ab, input int db,
                        input logic ega, input logic egb, input int exa, input int exb);
        req_a = ra; we_a = wa; addr_a = ADDR_W'(aa); wdata_a = DATA_W'(da);
        req_b = rb; we_b = wb; addr_b = ADDR_W'(ab); wdata_b = DATA_W'(db);
        @(negedge clk);
        check("gnt_a", 32'(gnt_a), 32'(ega));
        check("gnt_b", 32'(gnt_b), 32'(egb));
        if (ega && !wa) qa.push_back('{data: DATA_W'(exa), due: cyc + 1});
        if (egb && !wb) qb.push_back('{data: DATA_W'(exb), due: cyc + 1});
        @(posedge clk); #1;
    endtask

    // Called in the first cycle after reset releases; requests held high must be ignored.
    task automatic clear_seq();
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'd7;
        req_b = 1'b1; we_b = 1'b1; addr_b = 5'd9; wdata_b = 4'h5;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("clr_wr_en", 32'(ram_wr_en), 1);
            check("clr_addr", 32'(ram_addr), 32'(i));
            check("clr_wdata", 32'(ram_wr_data), 0);
            check("clr_gnt_a", 32'(gnt_a), 0);
            check("clr_gnt_b", 32'(gnt_b), 0);
            check("clr_init_done", 32'(init_done), 0);
            @(posedge clk); #1;
        end
        req_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
        @(negedge clk);
        check("init_done_rise", 32'(init_done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset, then the full clear sweep.
        @(posedge clk); @(posedge clk); #1;
        check("rst_rvalid_a", 32'(rvalid_a), 0);
        check("rst_rdata_b", 32'(rdata_b), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        clear_seq();

        // Test 2: A writes 5 <= A then reads it back.
        step(1, 1, 5, 4'hA, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 5, 0,    0, 0, 0, 0, 1, 0, 4'hA, 0);
        step(0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rdata_a_hold", 32'(rdata_a), 32'h0A);
        check("rdata_b_untouched", 32'(rdata_b), 0);
        @(posedge clk); #1;

        // Test 4: B alone, back-to-back writes then reads.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1, i, i + 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, i, 0,     0, 1, 0, i + 1);

        // Test 3: continuous contention, A reads addr 1 (=2), B reads addr 2 (=3).
        for (int r = 0; r < 2; r++) begin
            step(1, 0, 1, 0, 1, 0, 2, 0, 1, 0, 2, 0);
            step(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 0, 3);
        end

        // Test 6: B alone once, then a tie goes to A, then B.
        step(0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 0, 4);
        step(1, 0, 0, 0, 1, 0, 3, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 0, 4);

        // Test 5: write 31, read it, reset mid-traffic, clear again, read 31 as zero.
        step(1, 1, 31, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 31, 0,    0, 0, 0, 0, 1, 0, 4'hF, 0);
        reset_n = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 5'd31; wdata_a = 4'h3;
        @(negedge clk);
        check("rst_gnt_a", 32'(gnt_a), 0);
        check("rst_ram_wr_en", 32'(ram_wr_en), 1);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wr_data), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("rst_init_done", 32'(init_done), 0);
        check("rst_rdata_a", 32'(rdata_a), 0);
        clear_seq();
        step(1, 0, 31, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 5,  0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Controller that shares one 32x4 single-port RAM (synchronous write, combinational read) between two requesters, A and B.
- After reset it runs a clear sequence that writes 0 to every address.
- It then grants one requester per cycle using round-robin arbitration.
- It sits between the RAM and its two client blocks and owns every RAM control signal.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 4, RAM data width
DEPTH, 32, number of RAM words; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
req_a  input  1  requester A access request
we_a  input  1  A: 1 = write, 0 = read
addr_a  input  ADDR_W  A address
wdata_a  input  DATA_W  A write data
gnt_a  output  1  A access performed this cycle (combinational)
rvalid_a  output  1  A read data valid (registered)
rdata_a  output  DATA_W  A read data (registered)
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
init_done  output  1  high once the clear sequence completes (registered)
ram_wr_en  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_wr_data  output  DATA_W  RAM write data
ram_rd_data  input  DATA_W  RAM combinational read data

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset: reset_n low at a rising edge sets:
  - state = CLEAR, clr_cnt = 0, last_grant = B (so A wins the first tie)
  - init_done = 0, rvalid_a/b = 0, rdata_a/b = 0
  - While reset_n is low the combinational outputs follow CLEAR with clr_cnt = 0.
- State CLEAR:
  - ram_wr_en = 1, ram_addr = clr_cnt, ram_wr_data = 0.
  - clr_cnt increments each cycle.
  - On the cycle writing address DEPTH-1: next state = ARB, init_done <= 1.
  - The clear takes exactly DEPTH cycles. init_done is first high in cycle DEPTH+1 after reset deasserts and stays high until the next reset.
  - gnt_a and gnt_b are 0 and all requests are ignored.
- State ARB, grant logic (combinational, same cycle):
  - gnt_a = req_a & (~req_b | last_grant == B)
  - gnt_b = req_b & ~gnt_a
  - gnt_a and gnt_b are never both high.
- State ARB, RAM mux:
  - Granted requester drives ram_addr.
  - ram_wr_en = gnt & we.
  - ram_wr_data = the granted requester's wdata.
  - With no grant: ram_wr_en = 0, ram_addr = 0, ram_wr_data = 0.
- State ARB, last_grant: updated at the clock edge of any granted cycle; unchanged when idle.
- Reads:
  - If the granted access has we = 0, rdata_x <= ram_rd_data at the edge ending the grant cycle.
  - rvalid_x is then high for exactly one cycle. Latency is 1 cycle from gnt to rvalid.
  - rdata_x holds its value until the next read by that requester.
  - rvalid_x = 0 after a write or idle cycle.
- Writes: take effect at the edge ending the grant cycle. A read of the same address in the next cycle returns the new data.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen high.
  - Deassert req, or present the next access, in the cycle after gnt.
  - A requester holding req continuously alone is granted every cycle (full throughput).
- Contention:
  - Both requesting continuously alternate A, B, A, B.
  - Neither side waits more than 1 cycle.
- Reset mid-operation: clearing restarts from address 0. Any pending rvalid is suppressed. Granted accesses not yet complete are lost.
- Widths: clr_cnt is ADDR_W+1 bits so the terminal count is unambiguous. No other arithmetic.
- Only legal transitions: CLEAR→ARB, and any state→CLEAR on reset.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - typedef enum logic {CLEAR, ARB} arb_state_t
  - localparams ADDR_W, DATA_W, DEPTH
  - typedef enum logic {SEL_A, SEL_B} sel_t, used for last_grant
- One natural sub-module: rr_arbiter2. It is the 2-way round-robin grant logic plus the last_grant register, with inputs req_a, req_b, en and outputs gnt_a, gnt_b.
- The top level holds the clear counter, the RAM mux and the read-data registers.

Test Plan:
1. Release reset_n; monitor cycles 1-32 → ram_wr_en = 1, ram_addr = 0..31, ram_wr_data = 0; init_done rises at cycle 33; req_a asserted during clear gets gnt_a = 0.
2. After init, A writes addr 5 data 4'hA, then A reads addr 5 → gnt_a high each cycle; rvalid_a pulses one cycle after the read grant with rdata_a = 4'hA; rdata_b unchanged.
3. A and B both request continuously (A reads addr 1, B reads addr 2) → grants A,B,A,B; first grant goes to A; each rvalid pulses on alternate cycles.
4. B alone requests 4 back-to-back writes to addr 0..3 with data 1..4, then reads 0..3 → gnt_b high every cycle; reads return 1,2,3,4.
5. Write addr 31 = 4'hF, then pulse reset_n low 1 cycle mid-traffic → clear restarts at addr 0; after init_done, read addr 31 returns 4'h0; rvalid_a/b stay 0 through clear.
6. B requests alone for 1 cycle, then both request in the same cycle → A granted first (last_grant = B), then B.
